// File: rtl/axil_gpio_regs_pkg.sv
// Shared constants, types and helpers for the GPIO register block:
// register offsets, AXI response codes, field positions and byte-strobe expansion.
package gpio_regs_pkg;

  localparam logic [7:0] GPIO_ID_OFS      = 8'h00;
  localparam logic [7:0] GPIO_INPUTS_OFS  = 8'h04;
  localparam logic [7:0] GPIO_BTN_EVT_OFS = 8'h08;
  localparam logic [7:0] GPIO_LED_OFS     = 8'h0C;
  localparam logic [7:0] GPIO_SCRATCH_OFS = 8'h10;

  localparam logic [31:0] GPIO_ID_DEFAULT = 32'h4750_494F;

  localparam int INPUTS_SW_LSB  = 0;
  localparam int INPUTS_SW_W    = 4;
  localparam int INPUTS_BTN_LSB = 4;
  localparam int INPUTS_BTN_W   = 4;

  localparam int LED_RGB_LSB  = 0;
  localparam int LED_RGB_W    = 12;
  localparam int LED_MONO_LSB = 12;
  localparam int LED_MONO_W   = 4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    SEL_ID,
    SEL_INPUTS,
    SEL_BTN_EVT,
    SEL_LED,
    SEL_SCRATCH,
    SEL_NONE
  } reg_sel_e;

  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/axil_gpio_regs_if.sv
// AXI-Lite bus between the Ethernet command engine (master) and its register slaves.
// 32-bit address, 32-bit data, 4-bit write strobe.
interface AXIL_IF;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport Master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport Slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_gpio_regs_in_sync.sv
// Multi-flop synchronizer for asynchronous board inputs, followed by a delay
// flop that yields a one-cycle pulse on each rising edge of the synced value.
module gpio_in_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]             dly_q;

  // NOTE: non-blocking assignments let every stage sample the previous stage's
  // old value on the same edge; blocking ones would collapse the chain into one flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      dly_q  <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~dly_q;

endmodule

// File: rtl/axil_gpio_regs.sv
// AXI-Lite register slave for board switches, buttons and LEDs: ID, synced inputs,
// sticky W1C button events, LED drive and a scratch register.
module axil_gpio_regs
  import gpio_regs_pkg::*;
#(
  parameter logic [31:0] ID_VALUE      = GPIO_ID_DEFAULT,
  parameter logic [15:0] LED_RESET     = 16'h0000,
  parameter int          SYNC_STAGES   = 2,
  parameter int          DECODE_BITS   = 8,
  parameter logic [1:0]  UNMAPPED_RESP = 2'b10
) (
  input  logic         clk,
  input  logic         reset_n,
  AXIL_IF.Slave        axil_if,
  input  logic [3:0]   sw,
  input  logic [3:0]   btn,
  output logic [11:0]  led_rgb,
  output logic [3:0]   led_mono
);

  logic                   aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [DECODE_BITS-1:0] aw_addr_q, aw_addr_d;
  logic [31:0]            w_data_q, w_data_d;
  logic [3:0]             w_strb_q, w_strb_d;
  logic                   bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]             bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [15:0]            led_q, led_d;
  logic [31:0]            scratch_q, scratch_d;
  logic [3:0]             evt_q, evt_d;

  logic [3:0] sw_sync, btn_sync, btn_rise, unused_sw_rise, evt_clr;
  logic       unused_addr_bits;

  gpio_in_sync #(.WIDTH(4), .STAGES(SYNC_STAGES)) u_sw_sync (
    .clk(clk), .reset_n(reset_n), .d_i(sw), .sync_o(sw_sync), .rise_o(unused_sw_rise)
  );

  gpio_in_sync #(.WIDTH(4), .STAGES(SYNC_STAGES)) u_btn_sync (
    .clk(clk), .reset_n(reset_n), .d_i(btn), .sync_o(btn_sync), .rise_o(btn_rise)
  );

  assign unused_addr_bits = ^{axil_if.awaddr[31:DECODE_BITS], axil_if.araddr[31:DECODE_BITS]};

  function automatic reg_sel_e decode(input logic [DECODE_BITS-1:0] addr);
    logic [DECODE_BITS-1:0] ofs;
    ofs = addr & ~DECODE_BITS'(3);
    if (ofs == DECODE_BITS'(GPIO_ID_OFS))      return SEL_ID;
    if (ofs == DECODE_BITS'(GPIO_INPUTS_OFS))  return SEL_INPUTS;
    if (ofs == DECODE_BITS'(GPIO_BTN_EVT_OFS)) return SEL_BTN_EVT;
    if (ofs == DECODE_BITS'(GPIO_LED_OFS))     return SEL_LED;
    if (ofs == DECODE_BITS'(GPIO_SCRATCH_OFS)) return SEL_SCRATCH;
    return SEL_NONE;
  endfunction

  reg_sel_e    wr_sel, rd_sel;
  logic        commit, aw_hs, w_hs, ar_hs;
  logic [31:0] wmask, rd_data;

  assign aw_hs  = axil_if.awvalid & ~aw_held_q;
  assign w_hs   = axil_if.wvalid & ~w_held_q;
  assign ar_hs  = axil_if.arvalid & ~rvalid_q;
  assign commit = aw_held_q & w_held_q & ~bvalid_q;
  assign wr_sel = decode(aw_addr_q);
  assign rd_sel = decode(axil_if.araddr[DECODE_BITS-1:0]);
  assign wmask  = strb_to_mask(w_strb_q);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    led_d     = led_q;
    scratch_d = scratch_q;
    evt_clr   = '0;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_addr_d = axil_if.awaddr[DECODE_BITS-1:0];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = axil_if.wdata;
      w_strb_d = axil_if.wstrb;
    end

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = (wr_sel == SEL_NONE) ? UNMAPPED_RESP : OKAY;
      case (wr_sel)
        SEL_LED:     led_d     = (led_q & ~wmask[15:0]) | (w_data_q[15:0] & wmask[15:0]);
        SEL_SCRATCH: scratch_d = (scratch_q & ~wmask) | (w_data_q & wmask);
        SEL_BTN_EVT: if (w_strb_q[0]) evt_clr = w_data_q[3:0];
        default: ;
      endcase
    end else if (bvalid_q && axil_if.bready) begin
      bvalid_d = 1'b0;
    end

    // A fresh edge outranks a simultaneous clear so no press is ever lost.
    evt_d = (evt_q & ~evt_clr) | btn_rise;
  end

  always_comb begin
    rd_data = '0;
    case (rd_sel)
      SEL_ID: rd_data = ID_VALUE;
      SEL_INPUTS: begin
        rd_data[INPUTS_SW_LSB +: INPUTS_SW_W]   = sw_sync;
        rd_data[INPUTS_BTN_LSB +: INPUTS_BTN_W] = btn_sync;
      end
      SEL_BTN_EVT: rd_data[3:0]  = evt_q;
      SEL_LED:     rd_data[15:0] = led_q;
      SEL_SCRATCH: rd_data       = scratch_q;
      default: ;
    endcase

    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_data;
      rresp_d  = (rd_sel == SEL_NONE) ? UNMAPPED_RESP : OKAY;
    end else if (rvalid_q && axil_if.rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      led_q     <= LED_RESET;
      scratch_q <= '0;
      evt_q     <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      led_q     <= led_d;
      scratch_q <= scratch_d;
      evt_q     <= evt_d;
    end
  end

  assign axil_if.awready = ~aw_held_q;
  assign axil_if.wready  = ~w_held_q;
  assign axil_if.bvalid  = bvalid_q;
  assign axil_if.bresp   = bresp_q;
  assign axil_if.arready = ~rvalid_q;
  assign axil_if.rvalid  = rvalid_q;
  assign axil_if.rdata   = rdata_q;
  assign axil_if.rresp   = rresp_q;

  assign led_rgb  = led_q[LED_RGB_LSB +: LED_RGB_W];
  assign led_mono = led_q[LED_MONO_LSB +: LED_MONO_W];

endmodule

// File: doc/axil_gpio_regs.md
Name: axil_gpio_regs

Overview:
- AXI-Lite responder (slave) for the board switches, buttons and LEDs.
- Sits on the `AXIL_IF` driven by the Ethernet command engine (`eth_top`, master), as a peer of the RAM slave.
- Lets remote UDP commands read `sw`/`btn` and drive the RGB and mono LEDs.
- Provides sticky button-press events with write-1-to-clear semantics.

Parameters:
- `ID_VALUE`, `32'h4750_494F`, constant returned by the `ID` register.
- `LED_RESET`, `16'h0000`, reset value of the `LED` register.
- `SYNC_STAGES`, 2, flop stages in the `sw`/`btn` synchronizers; legal range 2..4.
- `DECODE_BITS`, 8, number of low address bits decoded; higher bits are ignored.
- `UNMAPPED_RESP`, `2'b10`, BRESP/RRESP for unmapped word offsets (SLVERR).

Ports:
- `clk`  in  1  single clock; all logic is on this clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `axil_if`  `AXIL_IF.Slave`  —  AXI-Lite slave, 32-bit address, 32-bit data, 4-bit WSTRB.
- `sw`  in  4  asynchronous slide switches.
- `btn`  in  4  asynchronous push buttons.
- `led_rgb`  out  12  `{led3_bgr, led2_bgr, led1_bgr, led0_bgr}`; bit 0 = `led0_r`, bit 1 = `led0_g`, bit 2 = `led0_b`, and so on.
- `led_mono`  out  4  `led4`..`led7`, bit 0 = `led4`.

Behaviour:
- Register map (byte offsets; decode uses `addr[DECODE_BITS-1:2]`):
  - `0x00` `ID`: read-only, `ID_VALUE`.
  - `0x04` `INPUTS`: read-only; `[3:0]` synced `sw`, `[7:4]` synced `btn`.
  - `0x08` `BTN_EVT`: `[3:0]` sticky rising-edge flags, write-1-to-clear.
  - `0x0C` `LED`: read/write; `[11:0]` `led_rgb`, `[15:12]` `led_mono`.
  - `0x10` `SCRATCH`: 32-bit read/write.
  - Unread or unmapped bits read as 0.
- Reset (asserted async, released sync on `clk`):
  - `awready`, `wready`, `arready` = 1.
  - `bvalid`, `rvalid` = 0; `bresp`, `rresp`, `rdata` = 0.
  - `LED` = `LED_RESET`; `SCRATCH` = 0; `BTN_EVT` = 0; synchronizer flops = 0.
  - Reset mid-transaction drops the transaction with no response.
- Write path:
  - AW and W are accepted independently into holding registers `aw_held`/`w_held`.
  - `awready` = `!aw_held`; `wready` = `!w_held`.
  - Commit edge: the first edge where `aw_held & w_held & !bvalid`.
    - The register updates on that edge and `bvalid` rises on that edge.
    - Both held flags clear on that edge.
  - Minimum latency: AW+W handshake on edge N, commit and `bvalid` on edge N+1.
  - `bvalid` holds until the `bready` handshake, then clears. A second AW/W may be captured while `bvalid` is high, but its commit waits for `bvalid` to clear.
  - WSTRB is honoured per byte for `LED` and `SCRATCH`.
  - `BTN_EVT` clear requires `wstrb[0]`.
  - Writes to read-only or unmapped offsets change nothing. `bresp` = OKAY for read-only mapped offsets, `UNMAPPED_RESP` for unmapped offsets.
- Read path:
  - `arready` = `!rvalid`.
  - On an AR handshake at edge N, `rdata`/`rresp` are registered at edge N and `rvalid` = 1 from edge N.
  - `rdata`/`rresp` hold stable until the `rready` handshake.
  - `rresp` = OKAY when mapped, `UNMAPPED_RESP` otherwise, with `rdata` = 0.
  - Read and commit on the same edge: the read returns the pre-commit value.
- Inputs:
  - `sw`/`btn` pass through `SYNC_STAGES` flops, then one extra delay flop for edge detection.
  - Rising edge on synced `btn[i]` sets `BTN_EVT[i]`.
  - Set and W1C on the same bit on the same edge: set wins.
- Outputs:
  - `led_rgb`/`led_mono` are driven directly from `LED` register flops, with no combinational path from the bus.

Decomposition:
- Package `gpio_regs_pkg`:
  - Register offset constants (`GPIO_ID_OFS` … `GPIO_SCRATCH_OFS`).
  - AXI response enum (`OKAY`/`SLVERR`/`DECERR`).
  - `ID` default.
  - Field LSB/width constants for `INPUTS` and `LED`.
- Sub-module `gpio_in_sync`:
  - Parameters: `WIDTH`, `STAGES`.
  - Outputs: synced value and a one-cycle rising-edge pulse vector.
  - Instantiated once for `sw` and once for `btn`.

Test Plan:
- Read `0x00` after reset → `rvalid` the cycle after AR handshake, `rdata` = `32'h4750494F`, `rresp` = `00`; `LED` reads `0x0000`.
- Write `0x0C` `data=0x0000F5A3 strb=4'b0011` → `bresp` `00`; `led_rgb` = `12'h5A3`, `led_mono` = `4'hF`. Then `strb=4'b0001 data=0x00` → `LED` reads `0xF500`.
- W presented 3 cycles before AW, `bready` held low 5 cycles → `wready` drops after capture; `bvalid` holds 5 cycles with stable `bresp`; the next AW/W is captured but not committed until the B handshake.
- Pulse `btn[2]` high for 10 cycles → `INPUTS[6]` = 1 after `SYNC_STAGES`+1 cycles; `BTN_EVT` = `0x4` after release. Write `0x08` `0x4` with `strb` 1 → reads `0x0`. Clear coincident with a new `btn[2]` edge → reads `0x4`.
- Read and write `0x40` (unmapped) → `rresp` = `bresp` = `10`, `rdata` = 0; `SCRATCH` unchanged.
- Write `SCRATCH` `0xDEADBEEF`, assert `reset_n` low mid-read with `rvalid` high → `rvalid`/`bvalid` 0 immediately (async), `SCRATCH` reads 0 after release.
